lineorder_date: RTL and testbench



---
 rtl/lo_date_pkg.sv | 36 +++
 rtl/date_bitmap_store.sv | 38 +++
 rtl/lineorder_date.sv | 63 ++++++
 tb/tb_lineorder_date.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lo_date_pkg.sv
// Shared types and sizing for the lineorder date join filter.
package lo_date_pkg;

  localparam int unsigned CL_W         = 512;
  localparam int unsigned KEY_W        = 16;
  localparam int unsigned KEYS_PER_CL  = CL_W / KEY_W;
  localparam int unsigned BITMAP_CLS   = 8;
  localparam int unsigned BITMAP_BITS  = BITMAP_CLS * CL_W;
  localparam int unsigned BITMAP_IDX_W = $clog2(BITMAP_BITS);
  localparam int unsigned LINE_IDX_W   = $clog2(BITMAP_CLS);
  localparam int unsigned BIT_IDX_W    = $clog2(CL_W);

  // Match-count field position inside bit_result.
  localparam int unsigned CNT_LSB      = 32;
  localparam int unsigned CNT_W        = 8;

  typedef logic [CL_W-1:0]                    cl_t;
  typedef logic [KEYS_PER_CL-1:0][KEY_W-1:0]  key_array_t;
  typedef logic [KEYS_PER_CL-1:0]             match_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_LOAD,
    OP_PROBE
  } op_e;

  function automatic logic [CNT_W-1:0] popcount(input match_t m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < KEYS_PER_CL; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/date_bitmap_store.sv
// Date selection bitmap: line-addressed write port, synchronous clear,
// and a KEYS_PER_CL-wide combinational bit lookup.
module date_bitmap_store
  import lo_date_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [LINE_IDX_W-1:0] wr_line,
  input  cl_t                   wr_data,
  input  key_array_t            keys,
  output match_t                match
);

  cl_t mem [BITMAP_CLS];

  // Line writes; reset clears every bitmap bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BITMAP_CLS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_line] <= wr_data;
    end
  end

  // One lookup per key lane; keys beyond the bitmap capacity never match.
  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < KEYS_PER_CL; k++) begin
      if (keys[k][KEY_W-1:BITMAP_IDX_W] == '0) begin
        match[k] = mem[keys[k][BITMAP_IDX_W-1:BIT_IDX_W]][keys[k][BIT_IDX_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/lineorder_date.sv
// Lineorder date join filter: loads a date bitmap, then probes packed
// orderdate keys against it and registers one match bit per key.
// Optional: LO_DATE_MATCH_COUNT_EN adds a match popcount in bit_result[39:32].
module lineorder_date
  import lo_date_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          reading_bitmap,
  input  logic          bitmap_ready,
  input  logic [31:0]   cls_processed,
  input  logic [511:0]  incoming_cl,
  output logic [511:0]  bit_result
);

  op_e        op;
  logic       wr_en;
  key_array_t keys;
  match_t     match;
  cl_t        next_result;

  // Strobe arbitration: a bitmap load wins over a probe in the same cycle.
  always_comb begin
    op = OP_IDLE;
    if (reading_bitmap) begin
      op = OP_LOAD;
    end else if (bitmap_ready) begin
      op = OP_PROBE;
    end
  end

  assign wr_en = (op == OP_LOAD) && (cls_processed < BITMAP_CLS);
  assign keys  = key_array_t'(incoming_cl);

  date_bitmap_store u_store (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_line (cls_processed[LINE_IDX_W-1:0]),
    .wr_data (incoming_cl),
    .keys    (keys),
    .match   (match)
  );

  // Assemble the probe result: match bits in the low lanes, rest zero.
  always_comb begin
    next_result = '0;
    next_result[KEYS_PER_CL-1:0] = match;
`ifdef LO_DATE_MATCH_COUNT_EN
    next_result[CNT_LSB +: CNT_W] = popcount(match);
`endif
  end

  // Result register updates only on a probe and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_result <= '0;
    end else if (op == OP_PROBE) begin
      bit_result <= next_result;
    end
  end

endmodule

// File: tb/tb_lineorder_date.sv
// Self-checking bench for lineorder_date against a bit-array reference model.
module tb_lineorder_date;

  logic         clk = 1'b0;
  logic         reset;
  logic         reading_bitmap;
  logic         bitmap_ready;
  logic [31:0]  cls_processed;
  logic [511:0] incoming_cl;
  logic [511:0] bit_result;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic         ref_bm [4096];
  logic [511:0] ref_res;

  lineorder_date dut (
    .clk            (clk),
    .reset          (reset),
    .reading_bitmap (reading_bitmap),
    .bitmap_ready   (bitmap_ready),
    .cls_processed  (cls_processed),
    .incoming_cl    (incoming_cl),
    .bit_result     (bit_result)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] model_probe(input logic [511:0] cl);
    logic [511:0] r;
    int unsigned  cnt;
    int unsigned  key;
    r = '0;
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      key = int'(cl[k*16 +: 16]);
      if (key < 4096 && ref_bm[key] === 1'b1) begin
        r[k] = 1'b1;
        cnt++;
      end
    end
`ifdef LO_DATE_MATCH_COUNT_EN
    r[39:32] = cnt[7:0];
`endif
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) ref_bm[i] = 1'b0;
    ref_res = '0;
  endtask

  // One clock with the given strobes; the model follows the same edge.
  task automatic step(input logic rb, input logic br, input logic [31:0] cls,
                      input logic [511:0] cl);
    reading_bitmap = rb;
    bitmap_ready   = br;
    cls_processed  = cls;
    incoming_cl    = cl;
    @(posedge clk);
    #1;
    reading_bitmap = 1'b0;
    bitmap_ready   = 1'b0;
    if (rb) begin
      if (cls < 8) begin
        for (int j = 0; j < 512; j++) ref_bm[cls*512 + j] = cl[j];
      end
    end else if (br) begin
      ref_res = model_probe(cl);
    end
  endtask

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] keys_line(input int unsigned seed_max);
    logic [511:0] l;
    for (int k = 0; k < 32; k++) l[k*16 +: 16] = 16'($urandom_range(0, seed_max));
    return l;
  endfunction

  logic [511:0] line;
  logic [511:0] held;
  logic [511:0] expc;

  initial begin
    reading_bitmap = 1'b0;
    bitmap_ready   = 1'b0;
    cls_processed  = '0;
    incoming_cl    = '0;
    reset          = 1'b1;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_state", bit_result, '0);

    // All-zero keys against an empty bitmap.
    step(1'b0, 1'b1, 32'd0, '0);
    check("probe_empty", bit_result, ref_res);
    check("probe_empty_const", bit_result, '0);

    // Line 0, bit 5 only.
    line = '0; line[5] = 1'b1;
    step(1'b1, 1'b0, 32'd0, line);
    check("load_holds_result", bit_result, ref_res);
    line = '0; line[15:0] = 16'd5; line[31:16] = 16'd6;
    step(1'b0, 1'b1, 32'd0, line);
    check("probe_key5", bit_result, ref_res);
    expc = '0; expc[0] = 1'b1;
`ifdef LO_DATE_MATCH_COUNT_EN
    expc[39:32] = 8'd1;
`endif
    check("probe_key5_const", bit_result, expc);

    // Line 3, bit 1 -> key 1537; probe via the top lane.
    line = '0; line[1] = 1'b1;
    step(1'b1, 1'b0, 32'd3, line);
    line = '0; line[511:496] = 16'd1537;
    step(1'b0, 1'b1, 32'd0, line);
    check("probe_1537", bit_result, ref_res);
    check("probe_1537_lane31", {511'd0, bit_result[31]}, 512'd1);
    line = '0; line[511:496] = 16'd1536;
    step(1'b0, 1'b1, 32'd0, line);
    check("probe_1536", bit_result, ref_res);

    // Out-of-range line index is dropped; out-of-range key misses.
    step(1'b1, 1'b0, 32'd8, '1);
    line = '0; line[15:0] = 16'd4100; line[31:16] = 16'd10;
    line[47:32] = 16'd5; line[63:48] = 16'd1537;
    step(1'b0, 1'b1, 32'd0, line);
    check("drop_oob_line", bit_result, ref_res);
    check("oob_key_lane0", {511'd0, bit_result[0]}, '0);

    // Both strobes: load wins, result holds.
    held = bit_result;
    line = '0; line[100] = 1'b1; line[0] = 1'b1;
    step(1'b1, 1'b1, 32'd2, line);
    check("both_strobes_hold", bit_result, held);
    line = '0; line[15:0] = 16'd1124; line[31:16] = 16'd1024; line[47:32] = 16'd1025;
    step(1'b0, 1'b1, 32'd7, line);
    check("both_strobes_stored", bit_result, ref_res);

    // Randomized mix of loads, probes and idle cycles.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          for (int w = 0; w < 16; w++) line[w*32 +: 32] = $urandom;
          step(1'b1, 1'b0, 32'($urandom_range(0, 9)), line);
          check("rand_load_hold", bit_result, ref_res);
        end
        1: begin
          step(1'b0, 1'b0, 32'd0, keys_line(65535));
          check("rand_idle_hold", bit_result, ref_res);
        end
        default: begin
          step(1'b0, 1'b1, 32'($urandom), keys_line(4200));
          check("rand_probe", bit_result, ref_res);
        end
      endcase
    end

    // Reset mid-operation clears result and bitmap.
    line = '1;
    step(1'b1, 1'b0, 32'd0, line);
    reset = 1'b1;
    step(1'b0, 1'b1, 32'd0, keys_line(511));
    reset = 1'b0;
    model_clear();
    check("mid_reset_result", bit_result, '0);
    step(1'b0, 1'b1, 32'd0, keys_line(4095));
    check("post_reset_probe", bit_result, ref_res);
    check("post_reset_probe_zero", bit_result, '0);

    // All-ones line 0; every key below 512 matches.
    step(1'b1, 1'b0, 32'd0, '1);
    step(1'b0, 1'b1, 32'd0, keys_line(511));
    check("full_match", bit_result, ref_res);
    check("full_match_low", {480'd0, bit_result[31:0]}, {480'd0, 32'hFFFF_FFFF});
`ifdef LO_DATE_MATCH_COUNT_EN
    check("full_match_count", {504'd0, bit_result[39:32]}, 512'd32);
`else
    check("full_match_count", {504'd0, bit_result[39:32]}, 512'd0);
`endif
    check("full_match_upper", {40'd0, bit_result[511:40]}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
